// File: rtl/commit_trace_encoder.sv
// commit_trace_encoder: captures retirement events into a FIFO and serializes them as a 16-bit trace word stream
module commit_trace_encoder #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [2:0]  WriteRegister,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    input  logic        Halt,
    output logic        trace_valid,
    output logic [15:0] trace_data,
    input  logic        trace_ready,
    output logic        almost_full,
    output logic        overflow,
    output logic        done,
    output logic [31:0] inst_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW+1)'(DEPTH - 1);

    typedef enum logic [3:0] {IDLE, REG0, REG1, LD0, LD1, LD2, ST0, ST1, ST2, HLT0, HLT1, HLT2, DONE} state_t;

    typedef struct packed {
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
        logic        h;
        logic [15:0] cyc;
        logic [15:0] ic;
    } ent_t;

    ent_t        mem_q [DEPTH];
    ent_t        ent_in, head, nxt, src;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q;
    state_t      state_q, state_d, seg_nx;
    logic        trace_valid_q, trace_valid_d, almost_full_q, almost_full_d;
    logic        overflow_q, overflow_d, done_q, done_d, halted_q, halted_d;
    logic [15:0] trace_data_q, trace_data_d, cycle_count_q, cycle_count_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic        commit, full, push, adv, pop, more;

    // First segment present in an entry at or after segment group g (0 REG, 1 LD, 2 ST, 3 HLT).
    function automatic state_t first_from(input logic [1:0] g, input ent_t e);
        return (g == 2'd0 && e.rw) ? REG0 :
               (g <= 2'd1 && e.mr) ? LD0 :
               (g <= 2'd2 && e.mw) ? ST0 :
               e.h ? HLT0 : IDLE;
    endfunction

    // Word presented on the stream while sitting in state s for entry e.
    function automatic logic [15:0] word_of(input state_t s, input ent_t e);
        case (s)
            REG0:    return {4'd1, e.wr, 9'd0};
            REG1:    return e.wd;
            LD0:     return {4'd2, 12'd0};
            LD1:     return e.addr;
            LD2:     return e.dout;
            ST0:     return {4'd3, 12'd0};
            ST1:     return e.addr;
            ST2:     return e.din;
            HLT0:    return {4'd4, 12'd0};
            HLT1:    return e.cyc;
            HLT2:    return e.ic;
            default: return 16'd0;
        endcase
    endfunction

    assign count_q = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign nxt     = mem_q[rd_ptr_q[AW-1:0] + 1'b1];

    // Capture side: decide push/drop, build the FIFO entry and update the counters.
    always_comb begin
        commit        = (RegWrite | MemRead | MemWrite | Halt) & ~halted_q;
        full          = count_q == FULL_CNT;
        push          = commit & ~full;
        overflow_d    = overflow_q | (commit & full);
        halted_d      = halted_q | (push & Halt);
        inst_count_d  = inst_count_q + 32'(commit & (RegWrite | MemWrite | Halt));
        cycle_count_d = cycle_count_q + 16'd1;
        ent_in.rw     = RegWrite;
        ent_in.wr     = WriteRegister;
        ent_in.wd     = WriteData;
        ent_in.mr     = MemRead;
        ent_in.mw     = MemWrite;
        ent_in.addr   = MemAddress;
        ent_in.din    = MemDataIn;
        ent_in.dout   = MemDataOut;
        ent_in.h      = Halt;
        ent_in.cyc    = cycle_count_q;
        ent_in.ic     = inst_count_d[15:0];
    end

    // Serializer: pick the next segment, pop at end of entry and chain straight into the next header.
    always_comb begin
        adv = trace_valid_q & trace_ready;
        case (state_q)
            REG0:    seg_nx = REG1;
            REG1:    seg_nx = first_from(2'd1, head);
            LD0:     seg_nx = LD1;
            LD1:     seg_nx = LD2;
            LD2:     seg_nx = first_from(2'd2, head);
            ST0:     seg_nx = ST1;
            ST1:     seg_nx = ST2;
            ST2:     seg_nx = first_from(2'd3, head);
            HLT0:    seg_nx = HLT1;
            HLT1:    seg_nx = HLT2;
            HLT2:    seg_nx = DONE;
            default: seg_nx = IDLE;
        endcase
        pop     = adv && (seg_nx == IDLE || seg_nx == DONE);
        more    = count_q > (AW+1)'(1);
        state_d = state_q;
        src     = head;
        if (state_q == IDLE) begin
            state_d = (count_q != '0) ? first_from(2'd0, head) : IDLE;
        end else if (state_q != DONE && adv) begin
            state_d = seg_nx;
            if (seg_nx == IDLE && more) begin
                state_d = first_from(2'd0, nxt);
                src     = nxt;
            end
        end
        trace_data_d  = (state_q == IDLE || adv) ? word_of(state_d, src) : trace_data_q;
        trace_valid_d = state_d != IDLE && state_d != DONE;
        done_d        = state_d == DONE;
        wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop};
        almost_full_d = (wr_ptr_d - rd_ptr_d) >= AF_CNT;
    end

    // Event storage; entries need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= ent_in;
    end

    // State, pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            trace_valid_q <= 1'b0;
            trace_data_q  <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            trace_valid_q <= trace_valid_d;
            trace_data_q  <= trace_data_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
            halted_q      <= halted_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_data  = trace_data_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign inst_count  = inst_count_q;
endmodule

// File: doc/commit_trace_encoder.md
# commit_trace_encoder

Hardware-side producer of the processor commit trace. Sits after the MEM/WB pipeline register, captures each cycle's retirement events (register write, load, store, halt) and serializes them as a 16-bit word stream over a valid/ready handshake. The stream drains to an on-chip trace sink or an FPGA debug port. It carries the same information the simulation trace bench logs, so silicon and simulation traces can be compared word for word.

## Interface
- DEPTH, 8: event FIFO entries; must be a power of two and at least 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  1  register file written this cycle.
- WriteRegister  in  3  destination register.
- WriteData  in  16  value written to the register.
- MemRead  in  1  load commits this cycle.
- MemWrite  in  1  store commits this cycle.
- MemAddress  in  16  load or store address.
- MemDataIn  in  16  store data.
- MemDataOut  in  16  load data.
- Halt  in  1  halt commits this cycle.
- trace_valid  out  1  trace_data holds a word.
- trace_data  out  16  stream word.
- trace_ready  in  1  sink accepts the word.
- almost_full  out  1  FIFO count ≥ DEPTH-1; the pipeline stalls commits while high.
- overflow  out  1  sticky; a commit was dropped.
- done  out  1  halt packet fully sent.
- inst_count  out  32  retired instruction count.

## Operation
- Commit cycle: any of RegWrite, MemRead, MemWrite, Halt is high, rst is low, and no halt has been captured yet.
- Capture on a commit cycle:
  - If count < DEPTH, push one entry holding all inputs plus a cycle_count snapshot.
  - If count == DEPTH, drop the commit and set overflow. inst_count still increments.
  - Commits after a captured Halt are ignored and are not counted.
- inst_count increments by 1 on a commit cycle with RegWrite|MemWrite|Halt.
  - MemRead alone does not count.
  - For a halt, the snapshot includes the halt itself.
- cycle_count is a 16-bit internal counter: 0 in the first cycle after reset, +1 every cycle, wraps at 16 bits.
- Header word layout:
  - [15:12] type: REG=1, LOAD=2, STORE=3, HALT=4.
  - [11:9] WriteRegister for REG, otherwise 0.
  - [8:0] always 0.
- Packets per entry, always emitted in the order REG, LOAD, STORE, HALT. Absent kinds are skipped.
  - REG: header, WriteData.
  - LOAD: header, MemAddress, MemDataOut.
  - STORE: header, MemAddress, MemDataIn.
  - HALT: header, cycle_count snapshot, inst_count[15:0] snapshot.
- Serializer states: IDLE, REG0, REG1, LD0, LD1, LD2, ST0, ST1, ST2, HLT0, HLT1, HLT2, DONE.
  - IDLE: if the FIFO is non-empty, go to the first present segment of the head entry.
  - Advance only on trace_valid & trace_ready. The last word of a segment jumps to the next present segment.
  - The last word of the entry pops the FIFO and returns to IDLE, or goes to DONE after HLT2.
  - DONE is absorbing until rst; done=1 and trace_valid=0 there.
- Reset values: trace_valid=0, trace_data=0, almost_full=0, overflow=0, done=0, inst_count=0. FIFO is empty, state is IDLE, cycle_count=0.

## Timing
- Capture to first word: an entry pushed at edge N is at the FIFO head after edge N. trace_valid rises after edge N+1; trace_data is registered.
- Throughput: one word per cycle while trace_ready=1. Back-to-back entries have no bubble: the pop and the next header load happen on the same edge.
- Handshake: once trace_valid=1, trace_valid and trace_data hold until accepted. trace_ready may change freely and has no combinational path to any output.
- Simultaneous push and pop at count==DEPTH: the push is dropped. Full is judged on the registered count; there is no bypass.
- almost_full is a registered function of the count and updates the cycle after a push or pop.
- rst mid-packet: the partial packet is abandoned. trace_valid=0 after the reset edge, the FIFO is emptied, and all counters and overflow are cleared.
- FIFO pointers are log2(DEPTH)+1 bits, so full and empty are distinguished across wrap-around.

## Test plan
- Single REG (r3←0xBEEF), ready=1 → words 0x1600, 0xBEEF on consecutive cycles; inst_count=1.
- Load r5 from 0x0040 returning 0x1234 (RegWrite+MemRead same cycle) → 0x1A00, 0x1234, 0x2000, 0x0040, 0x1234.
- Store 0xCAFE to 0x0010, with ready low for 3 cycles mid-packet → 0x3000, 0x0010, 0xCAFE; trace_data stable while stalled; no duplicated or lost words.
- ready=0 with 9 consecutive REG commits, DEPTH=8:
  - almost_full rises after the 7th push.
  - The 9th commit is dropped and overflow=1.
  - After ready=1, exactly 8 packets are emitted; inst_count=9.
- Halt at cycle_count 0x0020 after 4 counted instructions → 0x4000, 0x0020, 0x0005, then done=1.
  - A later RegWrite produces nothing and leaves inst_count at 5.
- rst asserted during word 2 of a STORE → trace_valid=0 next cycle and all outputs at reset values.
  - A post-reset REG commit streams normally.
